// File: rtl/sprdma_pkg.sv
// ---------------------------------------------------------------------------
// sprdma_pkg
// Shared NES constants used by the sprite DMA engine:
//   SPRDMA_TRIG_ADDR - CPU write address that starts a sprite DMA ($4014)
//   OAMDATA_ADDR     - PPU OAM data port the DMA writes into ($2004)
//   sprdma_state_t   - DMA sequencer state encodings
// ---------------------------------------------------------------------------
package sprdma_pkg;

    localparam logic [15:0] SPRDMA_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR     = 16'h2004;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        WRITE = 2'd3
    } sprdma_state_t;

endpackage

// File: rtl/sprdma.sv
// ---------------------------------------------------------------------------
// sprdma
// Sprite DMA engine. A CPU write of a page number to $4014 copies the 256
// bytes {page,00}..{page,FF} into the PPU OAM data port, one byte every three
// cycles (READ, LATCH, WRITE). While active_out is high the top level stalls
// the CPU and routes this block's bus outputs onto the memory bus.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   cpumc_a_in     in   CPU-side address bus (after debugger mux)
//   cpumc_din_in   in   CPU-side write data
//   cpumc_r_nw_in  in   CPU-side R/!W
//   cpumc_dout_in  in   ORed read-data bus, valid one cycle after the address
//   dbg_ready_in   in   debugger ready; 0 freezes the whole engine
//   active_out     out  DMA owns the bus
//   cpumc_a_out    out  DMA address
//   cpumc_d_out    out  DMA write data
//   cpumc_r_nw_out out  DMA R/!W
// ---------------------------------------------------------------------------
module sprdma
    import sprdma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpumc_a_in,
    input  logic [7:0]  cpumc_din_in,
    input  logic        cpumc_r_nw_in,
    input  logic [7:0]  cpumc_dout_in,
    input  logic        dbg_ready_in,
    output logic        active_out,
    output logic [15:0] cpumc_a_out,
    output logic [7:0]  cpumc_d_out,
    output logic        cpumc_r_nw_out
);

    sprdma_state_t state;
    logic [7:0]    page;
    logic [7:0]    addr;
    logic [7:0]    data;

    // Single sequencer: every output is a register loaded with the value that
    // belongs to the state being entered, so nothing on the outputs has a
    // combinational path from the inputs. A debugger break (dbg_ready_in=0)
    // simply skips all updates, which freezes state, counters and outputs and
    // lets the transfer resume exactly where it stopped. Reset wins over both
    // the break and a same-cycle trigger. LATCH holds the READ address so the
    // memory, which answers one cycle late, still sees the right address when
    // its data is captured at the end of LATCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            page           <= 8'h00;
            addr           <= 8'h00;
            data           <= 8'h00;
            active_out     <= 1'b0;
            cpumc_a_out    <= 16'h0000;
            cpumc_d_out    <= 8'h00;
            cpumc_r_nw_out <= 1'b1;
        end else if (dbg_ready_in) begin
            case (state)
                IDLE: begin
                    if (cpumc_a_in == SPRDMA_TRIG_ADDR && !cpumc_r_nw_in) begin
                        page           <= cpumc_din_in;
                        addr           <= 8'h00;
                        state          <= READ;
                        active_out     <= 1'b1;
                        cpumc_a_out    <= {cpumc_din_in, 8'h00};
                        cpumc_r_nw_out <= 1'b1;
                    end
                end
                READ: begin
                    state <= LATCH;
                end
                LATCH: begin
                    data           <= cpumc_dout_in;
                    state          <= WRITE;
                    cpumc_a_out    <= OAMDATA_ADDR;
                    cpumc_d_out    <= cpumc_dout_in;
                    cpumc_r_nw_out <= 1'b0;
                end
                WRITE: begin
                    addr <= addr + 8'd1;
                    if (addr == 8'hFF) begin
                        state          <= IDLE;
                        active_out     <= 1'b0;
                        cpumc_a_out    <= 16'h0000;
                        cpumc_d_out    <= 8'h00;
                        cpumc_r_nw_out <= 1'b1;
                    end else begin
                        state          <= READ;
                        cpumc_a_out    <= {page, addr + 8'd1};
                        cpumc_r_nw_out <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprdma.sv
// ---------------------------------------------------------------------------
// tb_sprdma
// Directed bench for the sprite DMA engine. A small memory model answers
// reads with the low address byte one cycle after the address, and a bus
// monitor logs every distinct read address and every write to $2004.
// ---------------------------------------------------------------------------
module tb_sprdma;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpumc_a_in;
    logic [7:0]  cpumc_din_in;
    logic        cpumc_r_nw_in;
    logic [7:0]  cpumc_dout_in;
    logic        dbg_ready_in;
    logic        active_out;
    logic [15:0] cpumc_a_out;
    logic [7:0]  cpumc_d_out;
    logic        cpumc_r_nw_out;

    int checks   = 0;
    int failures = 0;

    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;

    sprdma dut (
        .clk            (clk),
        .rst            (rst),
        .cpumc_a_in     (cpumc_a_in),
        .cpumc_din_in   (cpumc_din_in),
        .cpumc_r_nw_in  (cpumc_r_nw_in),
        .cpumc_dout_in  (cpumc_dout_in),
        .dbg_ready_in   (dbg_ready_in),
        .active_out     (active_out),
        .cpumc_a_out    (cpumc_a_out),
        .cpumc_d_out    (cpumc_d_out),
        .cpumc_r_nw_out (cpumc_r_nw_out)
    );

    always #10 clk = ~clk;

    // Memory model: registered read, data = low address byte
    always @(posedge clk) begin
        cpumc_dout_in <= (active_out && cpumc_r_nw_out) ? cpumc_a_out[7:0] : 8'h00;
    end

    // Bus monitor: log each new read address and each new write to $2004
    always @(negedge clk) begin
        logic cur_rd;
        logic cur_wr;
        cur_rd = active_out && cpumc_r_nw_out;
        cur_wr = active_out && !cpumc_r_nw_out && (cpumc_a_out == 16'h2004);
        if (cur_rd && !prev_rd) rd_q.push_back(cpumc_a_out);
        if (cur_wr && !prev_wr) wr_q.push_back(cpumc_d_out);
        prev_rd = cur_rd;
        prev_wr = cur_wr;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] din, input logic r_nw);
        cpumc_a_in    = a;
        cpumc_din_in  = din;
        cpumc_r_nw_in = r_nw;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_q.delete();
    endtask

    // Returns at the negedge where state is READ of byte 0 (offset 0)
    task automatic trigger(input logic [7:0] pg);
        @(negedge clk);
        applyStimulus(16'h4014, pg, 1'b0);
        @(negedge clk);
        applyStimulus(16'h0000, 8'h00, 1'b1);
    endtask

    // Counts remaining active cycles, bounded
    task automatic wait_idle(output int c);
        c = 0;
        while (active_out && c < 3000) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(16'h0000, 8'h00, 1'b1);
        dbg_ready_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (active_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_active: got %b expected 0", active_out);
        end
        checks++;
        if (cpumc_a_out !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_addr: got %h expected 0000", cpumc_a_out);
        end
        checks++;
        if (cpumc_d_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h expected 00", cpumc_d_out);
        end
        checks++;
        if (cpumc_r_nw_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_rnw: got %b expected 1", cpumc_r_nw_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_dma();
        int c;
        int bad;
        clear_logs();
        trigger(8'h02);
        checks++;
        if (cpumc_a_out !== 16'h0200 || cpumc_r_nw_out !== 1'b1 || active_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_first_read: got %h/%b/%b expected 0200/1/1", cpumc_a_out, cpumc_r_nw_out, active_out);
        end
        wait_idle(c);
        checks++;
        if (c !== 768) begin
            failures++;
            $display("[TB] FAIL full_active_cycles: got %0d expected 768", c);
        end
        checks++;
        if (wr_q.size() !== 256) begin
            failures++;
            $display("[TB] FAIL full_write_count: got %0d expected 256", wr_q.size());
        end
        bad = -1;
        foreach (wr_q[i]) if (bad < 0 && wr_q[i] !== 8'(i)) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("[TB] FAIL full_write_data: index %0d got %h expected %h", bad, wr_q[bad], 8'(bad));
        end
        bad = -1;
        foreach (rd_q[i]) if (bad < 0 && rd_q[i] !== {8'h02, 8'(i)}) bad = i;
        checks++;
        if (bad >= 0 || rd_q.size() !== 256) begin
            failures++;
            $display("[TB] FAIL full_read_addr: index %0d count %0d expected 256 reads from page 02", bad, rd_q.size());
        end
        checks++;
        if (active_out !== 1'b0 || cpumc_a_out !== 16'h0000 || cpumc_d_out !== 8'h00 || cpumc_r_nw_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_idle_outputs: got %b/%h/%h/%b expected 0/0000/00/1", active_out, cpumc_a_out, cpumc_d_out, cpumc_r_nw_out);
        end
    endtask

    task automatic test_retrigger_ignored();
        int c;
        int bad;
        clear_logs();
        trigger(8'h03);
        for (int i = 0; i < 99; i++) @(negedge clk);
        applyStimulus(16'h4014, 8'h07, 1'b0);
        @(negedge clk);
        applyStimulus(16'h0000, 8'h00, 1'b1);
        wait_idle(c);
        checks++;
        if (c + 100 !== 768) begin
            failures++;
            $display("[TB] FAIL retrig_active_cycles: got %0d expected 768", c + 100);
        end
        bad = -1;
        foreach (rd_q[i]) if (bad < 0 && rd_q[i] !== {8'h03, 8'(i)}) bad = i;
        checks++;
        if (bad >= 0 || rd_q.size() !== 256) begin
            failures++;
            $display("[TB] FAIL retrig_read_page: index %0d count %0d expected 256 reads from page 03", bad, rd_q.size());
        end
        checks++;
        if (wr_q.size() !== 256) begin
            failures++;
            $display("[TB] FAIL retrig_write_count: got %0d expected 256", wr_q.size());
        end
    endtask

    task automatic test_dbg_freeze();
        int c;
        int bad;
        int frozen_bad;
        int ones;
        clear_logs();
        trigger(8'h02);
        for (int i = 0; i < 193; i++) @(negedge clk);
        checks++;
        if (cpumc_a_out !== 16'h0240 || cpumc_r_nw_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL freeze_latch_pos: got %h/%b expected 0240/1", cpumc_a_out, cpumc_r_nw_out);
        end
        dbg_ready_in = 1'b0;
        frozen_bad = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (cpumc_a_out !== 16'h0240 || cpumc_r_nw_out !== 1'b1 || active_out !== 1'b1)
                frozen_bad++;
        end
        checks++;
        if (frozen_bad !== 0) begin
            failures++;
            $display("[TB] FAIL freeze_hold: got %0d changed cycles expected 0", frozen_bad);
        end
        dbg_ready_in = 1'b1;
        wait_idle(c);
        checks++;
        if (c + 243 !== 818) begin
            failures++;
            $display("[TB] FAIL freeze_total_cycles: got %0d expected 818", c + 243);
        end
        checks++;
        if (wr_q.size() !== 256) begin
            failures++;
            $display("[TB] FAIL freeze_write_count: got %0d expected 256", wr_q.size());
        end
        bad = -1;
        ones = 0;
        foreach (wr_q[i]) begin
            if (bad < 0 && wr_q[i] !== 8'(i)) bad = i;
            if (wr_q[i] === 8'h40) ones++;
        end
        checks++;
        if (bad >= 0 || ones !== 1) begin
            failures++;
            $display("[TB] FAIL freeze_write_data: first bad index %0d, byte 40 seen %0d times expected 1", bad, ones);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        trigger(8'h05);
        for (int i = 0; i < 386; i++) @(negedge clk);
        checks++;
        if (cpumc_a_out !== 16'h2004 || cpumc_r_nw_out !== 1'b0 || cpumc_d_out !== 8'h80) begin
            failures++;
            $display("[TB] FAIL rstmid_write_pos: got %h/%b/%h expected 2004/0/80", cpumc_a_out, cpumc_r_nw_out, cpumc_d_out);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (active_out !== 1'b0 || cpumc_a_out !== 16'h0000 || cpumc_d_out !== 8'h00 || cpumc_r_nw_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_idle: got %b/%h/%h/%b expected 0/0000/00/1", active_out, cpumc_a_out, cpumc_d_out, cpumc_r_nw_out);
        end
        rst = 1'b0;
        n = wr_q.size();
        checks++;
        if (n !== 129) begin
            failures++;
            $display("[TB] FAIL rstmid_writes_at_reset: got %0d expected 129", n);
        end
        repeat (800) @(negedge clk);
        checks++;
        if (wr_q.size() !== 129 || active_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_no_more_writes: got %0d writes active %b expected 129 and 0", wr_q.size(), active_out);
        end
    endtask

    task automatic test_page_wrap();
        int c;
        clear_logs();
        trigger(8'hFF);
        wait_idle(c);
        checks++;
        if (c !== 768 || rd_q.size() !== 256) begin
            failures++;
            $display("[TB] FAIL wrap_counts: got %0d cycles %0d reads expected 768 and 256", c, rd_q.size());
        end
        checks++;
        if (rd_q.size() < 256 || rd_q[0] !== 16'hFF00 || rd_q[255] !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL wrap_read_ends: got %0d reads expected first FF00 last FFFF", rd_q.size());
        end
        clear_logs();
        trigger(8'h20);
        checks++;
        if (cpumc_a_out !== 16'h2000) begin
            failures++;
            $display("[TB] FAIL wrap_addr_restart: got %h expected 2000", cpumc_a_out);
        end
        wait_idle(c);
        checks++;
        if (c !== 768 || wr_q.size() !== 256) begin
            failures++;
            $display("[TB] FAIL ppu_page_dma: got %0d cycles %0d writes expected 768 and 256", c, wr_q.size());
        end
    endtask

    task automatic test_no_trigger();
        int seen;
        clear_logs();
        seen = 0;
        @(negedge clk);
        applyStimulus(16'h4014, 8'h02, 1'b1);
        @(negedge clk);
        applyStimulus(16'h0000, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (active_out !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("[TB] FAIL read_no_dma: got %0d active cycles expected 0", seen);
        end
        seen = 0;
        rst = 1'b1;
        applyStimulus(16'h4014, 8'h09, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(16'h0000, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (active_out !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("[TB] FAIL rst_trigger_ignored: got %0d active cycles expected 0", seen);
        end
        seen = 0;
        dbg_ready_in = 1'b0;
        applyStimulus(16'h4014, 8'h0A, 1'b0);
        @(negedge clk);
        dbg_ready_in = 1'b1;
        applyStimulus(16'h0000, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (active_out !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0 || wr_q.size() !== 0) begin
            failures++;
            $display("[TB] FAIL dbg_break_trigger: got %0d active cycles %0d writes expected 0 and 0", seen, wr_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        dbg_ready_in = 1'b1;
        applyStimulus(16'h0000, 8'h00, 1'b1);
        test_reset();
        test_full_dma();
        test_retrigger_ignored();
        test_dbg_freeze();
        test_reset_mid();
        test_page_wrap();
        test_no_trigger();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprdma.md
SPRDMA -- requirements
Module: sprdma

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (50 MHz).
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have: cpumc_a_in  in  16  CPU-side address bus, post debugger mux.
REQ-004 SHALL have: cpumc_din_in  in  8  CPU-side write data.
REQ-005 SHALL have: cpumc_r_nw_in  in  1  CPU-side R/!W.
REQ-006 SHALL have: cpumc_dout_in  in  8  ORed read-data bus from cpumc, ppu and jp.
REQ-007 SHALL have: dbg_ready_in  in  1  debugger ready; 0 means break.
REQ-008 SHALL have: active_out  in/out n/a; output  1  DMA owns bus. Top level ANDs !active_out into CPU ready and selects the sprdma bus outputs.
REQ-009 SHALL have: cpumc_a_out  out  16  DMA address.
REQ-010 SHALL have: cpumc_d_out  out  8  DMA write data.
REQ-011 SHALL have: cpumc_r_nw_out  out  1  DMA R/!W.

Function
REQ-012 SHALL use states IDLE, READ, LATCH and WRITE, with state change only on rising clk.
REQ-013 In IDLE, a cycle with cpumc_a_in=0x4014, cpumc_r_nw_in=0 and dbg_ready_in=1 SHALL capture page=cpumc_din_in and addr=0x00, and SHALL enter READ next cycle.
REQ-014 Writes to 0x4014 while not IDLE SHALL be ignored, with page left unchanged.
REQ-015 In READ, the block SHALL drive cpumc_a_out={page,addr} and cpumc_r_nw_out=1, then go to LATCH.
REQ-016 In LATCH, the block SHALL hold the READ address and R/!W, capture cpumc_dout_in into data at end of cycle (one-cycle read latency), then go to WRITE.
REQ-017 In WRITE, the block SHALL drive cpumc_a_out=0x2004, cpumc_d_out=data and cpumc_r_nw_out=0.
REQ-018 On leaving WRITE, addr SHALL increment mod 256; if addr was 0xFF the next state SHALL be IDLE, otherwise READ.
REQ-019 One DMA SHALL be exactly 256 bytes in 768 active cycles when there are no stalls.
REQ-020 active_out SHALL be 1 exactly when state≠IDLE (registered, no combinational path from inputs).
REQ-021 In IDLE, outputs SHALL be cpumc_a_out=0x0000, cpumc_d_out=0x00 and cpumc_r_nw_out=1.
REQ-022 dbg_ready_in=0 SHALL freeze state, addr, page and data, and SHALL hold all outputs.
REQ-023 On return to dbg_ready_in=1, the block SHALL resume from the frozen state with no byte skipped or repeated.
REQ-024 Page 0x20–0x3F (PPU-register source) and page 0x40 SHALL be legal, with no special handling.
REQ-025 A trigger in the same cycle as rst=1 SHALL be ignored.

Reset
REQ-026 rst=1 SHALL force IDLE, page=0x00, addr=0x00, data=0x00, active_out=0 and the IDLE output values at the next rising edge, including mid-transfer.
REQ-027 After reset is released, no write SHALL reach 0x2004 until a new 0x4014 write occurs.

Structure
REQ-028 Constants SPRDMA_TRIG_ADDR=0x4014 and OAMDATA_ADDR=0x2004, plus the state encodings, SHALL live in the shared NES constants include, not local literals.
REQ-029 The block SHALL be a single flat module with no sub-module.
REQ-030 The top level SHALL give the DMA bus priority over both the CPU and the debugger whenever active_out=1.

Verification
REQ-031 The bench SHALL check: write 0x02 to 0x4014 with memory 0x0200+i=i -> 256 writes to 0x2004 with data 0x00..0xFF in order, active_out high for 768 cycles, then IDLE.
REQ-032 The bench SHALL check: trigger, then a second 0x4014 write (value 0x07) at cycle 100 -> ignored, all reads from page 0x03 (first trigger value 0x03).
REQ-033 The bench SHALL check: dbg_ready_in=0 for 50 cycles during LATCH of byte 0x40 -> outputs frozen, then byte 0x40 is written exactly once and the total is 256 writes.
REQ-034 The bench SHALL check: rst asserted during WRITE of byte 0x80 -> next cycle IDLE, active_out=0, no further 0x2004 writes.
REQ-035 The bench SHALL check: page 0xFF trigger -> last read at 0xFFFF, addr wraps to 0x00, and the block returns to IDLE without a 257th read.
REQ-036 The bench SHALL check: read of 0x4014 (cpumc_r_nw_in=1) -> no DMA starts.
